seq_det_scheduler: RTL and testbench
====================================

Name: seq_det_scheduler

Overview:
- Time-shares one "1001" overlapping sequence-detection engine among NCH independent serial bit streams.
- Holds a per-channel context: bit history, fill level and match counter.
- Arbitrates requesters round-robin and consumes one bit per cycle from the granted channel.
- Reports detections with channel ID. Sits between the serial stream sources and the detect/event logic, replacing one detector FSM per stream.

Parameters:
- NCH, 4, number of requesting channels (2..16).
- PAT_W, 4, pattern length in bits (2..8).
- PATTERN, 4'b1001, bit pattern; MSB is the oldest bit.
- CNT_W, 8, width of each per-channel match counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  engine enable; when low, no grants and all state holds.
- req  in  NCH  per-channel bit-valid; held until granted.
- bit_in  in  NCH  per-channel serial bit, stable while req is high.
- gnt  out  NCH  one-hot combinational grant; the bit is consumed at the edge where req[c]&gnt[c].
- clr  in  1  clear strobe for channel clr_ch.
- clr_ch  in  $clog2(NCH)  channel to clear.
- det_valid  out  1  registered one-cycle detection pulse.
- det_ch  out  $clog2(NCH)  channel of the detection; valid with det_valid.
- rd_ch  in  $clog2(NCH)  counter read select.
- rd_cnt  out  CNT_W  combinational match count of channel rd_ch.

Behaviour:
- Reset (rst=0, async) clears all outputs and state:
  - ptr=0; hist[*]=0; fill[*]=0; cnt[*]=0; det_valid=0; det_ch=0.
  - gnt=0 while rst is low.
- Grant:
  - gnt=0 when en=0 or req=0.
  - Otherwise, grant the first channel with req set, searching ptr, ptr+1, ... modulo NCH.
  - Exactly one bit of gnt is set.
- Pointer: on a consumption edge for channel c, ptr <= (c+1) mod NCH. Otherwise ptr holds. The pointer wraps NCH-1 -> 0.
- Consumption for channel c, at the edge:
  - hist[c] <= {hist[c][PAT_W-2:0], bit_in[c]}.
  - fill[c] <= min(fill[c]+1, PAT_W).
- Match: the new hist equals PATTERN and the new fill equals PAT_W. On a match, at the same edge:
  - det_valid <= 1 and det_ch <= c.
  - cnt[c] <= cnt[c]+1, saturating at 2^CNT_W-1 (no wrap).
- det_valid is 0 after any edge without a match. Latency is 1 cycle from the consuming edge, so consecutive matches give back-to-back pulses.
- Overlap allowed: the history is not flushed on a match. The stream 1001001 on one channel gives 2 matches.
- Channel contexts are fully independent; bits of different channels never mix.
- Clear (clr=1):
  - At the edge, hist, fill and cnt of clr_ch go to 0.
  - gnt[clr_ch] is forced to 0 that cycle, and arbitration skips to the next requester.
  - Clear therefore never races with a consumption. ptr is unaffected unless another channel is granted.
- en=0: no consumption and no detection; clear still functions; det_valid returns to 0.
- rd_cnt is combinational. It reflects pre-edge values (a same-cycle increment is visible the next cycle).
- A bit presented with fill<PAT_W can never match, which prevents false matches from reset zeros.

Optional Feature:
- SEQ_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins. ptr is unused and tied to 0.
- Undefined (default): round-robin as specified.

Test Plan:
- Single stream: after reset, req[0]=1 only, bit_in[0] = 1,0,0,1,0,0,1 on consecutive cycles.
  - gnt=4'b0001 every cycle.
  - det_valid pulses the cycle after the 4th and 7th bits, det_ch=0 both times.
  - rd_ch=0 gives rd_cnt=2.
- Round-robin: req=4'b1111 held.
  - gnt sequence 0001,0010,0100,1000,0001.
  - Each channel is fed 1,0,0,1 over its own 4 grants; the channel 3 match fires the cycle after the 16th grant, det_ch=3.
- Interleaved no-crosstalk: ch1 gets 1,0 and ch2 gets 0,1, alternating.
  - No detection is raised.
  - ch1 later gets 0,1: det_ch=1, and ch2's hist is unchanged (01).
- Clear collision: ptr=2, req=4'b0100, clr=1, clr_ch=2.
  - gnt=0 that cycle.
  - ch2 hist/fill/cnt become 0.
  - A subsequent 1,0,0,1 on ch2 is needed to detect.
- Saturation: with CNT_W=2, drive 5 matches on ch0 (1001001001001001 pattern overlaps).
  - rd_cnt saturates at 3 and does not wrap.
- Async reset mid-stream: assert rst=0 between clock edges after ch0 has 1,0,0.
  - det_valid=0 and gnt=0 immediately.
  - After release, a single 1 does not detect; a full 1,0,0,1 does.

Source files
------------

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: one overlapping PATTERN detector time-shared across NCH serial streams.
// det_valid lands 1 cycle after the consuming edge; a stream holds req until granted. `SEQ_SCHED_FIXED_PRIO_EN: fixed priority.
module seq_det_scheduler #(
  parameter int NCH = 4,
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter int CNT_W = 8,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   bit_in,
  output logic [NCH-1:0]   gnt,
  input  logic             clr,
  input  logic [CH_W-1:0]  clr_ch,
  output logic             det_valid,
  output logic [CH_W-1:0]  det_ch,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [CH_W-1:0]   ptr;
  logic [PAT_W-1:0]  hist [NCH];
  logic [FILL_W-1:0] fill [NCH];
  logic [CNT_W-1:0]  cnt  [NCH];

  logic [NCH-1:0]    clr_mask;
  logic [NCH-1:0]    avail;
  logic [CH_W-1:0]   idx;
  logic              found;
  logic [CH_W-1:0]   gidx;
  logic              consume;
  logic [PAT_W-1:0]  nxt_hist;
  logic [FILL_W-1:0] nxt_fill;
  logic              match;

  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NCH) sum = sum - NCH;
    return CH_W'(sum);
  endfunction

  // A channel being cleared is masked out so clear and consumption never collide.
  always_comb begin
    clr_mask = '0;
    for (int c = 0; c < NCH; c++) begin
      clr_mask[c] = clr && (int'(clr_ch) == c);
    end
  end

  assign avail = req & ~clr_mask;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    if (rst && en) begin
      for (int i = 0; i < NCH; i++) begin
        idx = wrap_inc(ptr, i);
        if (!found && avail[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt[c]) gidx = CH_W'(c);
    end
  end

  assign consume  = |gnt;
  assign nxt_hist = {hist[gidx][PAT_W-2:0], bit_in[gidx]};
  assign nxt_fill = (fill[gidx] == FILL_FULL) ? FILL_FULL : fill[gidx] + 1'b1;
  // A full fill is required so reset zeros in the history can never fake a match.
  assign match    = consume && (nxt_hist == PATTERN) && (nxt_fill == FILL_FULL);

`ifdef SEQ_SCHED_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (consume) begin
      ptr <= wrap_inc(gidx, 1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        hist[c] <= '0;
        fill[c] <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (clr_mask[c]) begin
          hist[c] <= '0;
          fill[c] <= '0;
          cnt[c]  <= '0;
        end else if (gnt[c]) begin
          hist[c] <= nxt_hist;
          fill[c] <= nxt_fill;
          if (match && (cnt[c] != {CNT_W{1'b1}})) cnt[c] <= cnt[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_valid <= 1'b0;
      det_ch    <= '0;
    end else begin
      det_valid <= match;
      if (match) det_ch <= gidx;
    end
  end

  always_comb begin
    rd_cnt = '0;
    if (int'(rd_ch) < NCH) rd_cnt = cnt[rd_ch];
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_seq_det_scheduler;

  localparam int NCH   = 4;
  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;
  localparam int PATV  = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b1;
  logic [NCH-1:0]   req = '0;
  logic [NCH-1:0]   bit_in = '0;
  logic [NCH-1:0]   gnt;
  logic             clr = 1'b0;
  logic [1:0]       clr_ch = '0;
  logic             det_valid;
  logic [1:0]       det_ch;
  logic [1:0]       rd_ch = '0;
  logic [CNT_W-1:0] rd_cnt;

  int total = 0;
  int bad   = 0;

  bit mq [NCH][$];
  int m_cnt [NCH];
  int m_ptr;
  bit m_det;
  int m_det_ch;

  logic [NCH-1:0] g;

  always #5 clk = ~clk;

  seq_det_scheduler #(.NCH(NCH), .PAT_W(PAT_W), .PATTERN(4'b1001), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .bit_in(bit_in), .gnt(gnt),
    .clr(clr), .clr_ch(clr_ch), .det_valid(det_valid), .det_ch(det_ch),
    .rd_ch(rd_ch), .rd_cnt(rd_cnt)
  );

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      mq[k].delete();
      m_cnt[k] = 0;
    end
    m_ptr = 0;
    m_det = 1'b0;
    m_det_ch = 0;
  endtask

  function automatic logic [NCH-1:0] model_gnt();
    logic [NCH-1:0] r;
    r = '0;
    if (!rst || !en) return r;
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (m_ptr + i) % NCH;
      if (req[c] && !(clr && int'(clr_ch) == c)) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Advance one clock edge and apply the stream rules to the model.
  task automatic step(output logic [NCH-1:0] gg);
    int v;
    gg = model_gnt();
    @(posedge clk);
    m_det = 1'b0;
    if (clr) begin
      mq[clr_ch].delete();
      m_cnt[clr_ch] = 0;
    end
    for (int k = 0; k < NCH; k++) begin
      if (gg[k]) begin
        mq[k].push_back(bit_in[k]);
        if (mq[k].size() > PAT_W) void'(mq[k].pop_front());
        if (mq[k].size() == PAT_W) begin
          v = 0;
          for (int j = 0; j < mq[k].size(); j++) v = (v << 1) | int'(mq[k][j]);
          if (v == PATV) begin
            m_det = 1'b1;
            m_det_ch = k;
            if (m_cnt[k] < CMAX) m_cnt[k]++;
          end
        end
        m_ptr = (k + 1) % NCH;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; en = 1'b1; req = '0; bit_in = '0; clr = 1'b0; clr_ch = '0; rd_ch = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b0;
    req = '1;
    #1;
    model_reset();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    total++; if (det_valid !== 1'b0) begin bad++; $display("FAIL rst_det_valid got=%b exp=0", det_valid); end
    total++; if (det_ch !== 2'd0) begin bad++; $display("FAIL rst_det_ch got=%0d exp=0", det_ch); end
    for (int k = 0; k < NCH; k++) begin
      rd_ch = 2'(k);
      #1;
      total++; if (rd_cnt !== 2'd0) begin bad++; $display("FAIL rst_cnt ch=%0d got=%0d exp=0", k, rd_cnt); end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    #1;
  endtask

  task automatic test_single_stream();
    logic [6:0] s;
    logic exp;
    s = 7'b1001001;
    apply_reset();
    req = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      bit_in = {3'b000, s[6-k]};
      #1;
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL ss_gnt k=%0d got=%b exp=0001", k, gnt); end
      step(g);
      exp = (k == 3 || k == 6);
      total++; if (det_valid !== exp) begin bad++; $display("FAIL ss_det k=%0d got=%b exp=%b", k, det_valid, exp); end
      if (exp) begin
        total++; if (det_ch !== 2'd0) begin bad++; $display("FAIL ss_det_ch k=%0d got=%0d exp=0", k, det_ch); end
      end
    end
    req = '0;
    rd_ch = 2'd0;
    #1;
    total++; if (rd_cnt !== 2'd2) begin bad++; $display("FAIL ss_cnt got=%0d exp=2", rd_cnt); end
    step(g);
    total++; if (det_valid !== 1'b0) begin bad++; $display("FAIL ss_idle_det got=%b exp=0", det_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] s4;
    logic b, exp;
    logic [NCH-1:0] eg;
    s4 = 4'b1001;
    apply_reset();
    req = '1;
    for (int j = 0; j < 17; j++) begin
      b = (j < 16) ? s4[3 - (j / 4)] : 1'b0;
      bit_in = {4{b}};
      #1;
      eg = 4'b0001 << (j % 4);
      total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt j=%0d got=%b exp=%b", j, gnt, eg); end
      step(g);
      exp = (j >= 12 && j < 16);
      total++; if (det_valid !== exp) begin bad++; $display("FAIL rr_det j=%0d got=%b exp=%b", j, det_valid, exp); end
      if (exp) begin
        total++; if (int'(det_ch) != j % 4) begin bad++; $display("FAIL rr_det_ch j=%0d got=%0d exp=%0d", j, det_ch, j % 4); end
      end
    end
    req = '0;
    for (int k = 0; k < NCH; k++) begin
      rd_ch = 2'(k);
      #1;
      total++; if (rd_cnt !== 2'd1) begin bad++; $display("FAIL rr_cnt ch=%0d got=%0d exp=1", k, rd_cnt); end
    end
  endtask

  task automatic test_no_crosstalk();
    int ch_t [9] = '{1, 2, 1, 2, 1, 1, 2, 2, 2};
    bit b_t  [9] = '{1, 0, 0, 1, 0, 1, 0, 0, 1};
    int d_t  [9] = '{-1, -1, -1, -1, -1, 1, -1, -1, 2};
    logic [NCH-1:0] eg;
    logic exp;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      eg = 4'b0001 << ch_t[i];
      req = eg;
      bit_in = 4'($urandom);
      bit_in[ch_t[i]] = b_t[i];
      #1;
      total++; if (gnt !== eg) begin bad++; $display("FAIL xt_gnt i=%0d got=%b exp=%b", i, gnt, eg); end
      step(g);
      exp = (d_t[i] >= 0);
      total++; if (det_valid !== exp) begin bad++; $display("FAIL xt_det i=%0d got=%b exp=%b", i, det_valid, exp); end
      if (exp) begin
        total++; if (int'(det_ch) != d_t[i]) begin bad++; $display("FAIL xt_det_ch i=%0d got=%0d exp=%0d", i, det_ch, d_t[i]); end
      end
    end
    req = '0;
  endtask

  task automatic test_clear_collision();
    logic [3:0] s4;
    bit b2 [6] = '{0, 1, 1, 0, 0, 1};
    logic exp;
    s4 = 4'b1001;
    apply_reset();
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      bit_in = {1'b0, s4[3-k], 2'b00};
      #1;
      step(g);
    end
    total++; if (det_valid !== 1'b1 || det_ch !== 2'd2) begin bad++; $display("FAIL cc_pre_det got=%b/%0d exp=1/2", det_valid, det_ch); end
    req = 4'b0010;
    bit_in = '0;
    #1;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL cc_ch1_gnt got=%b exp=0010", gnt); end
    step(g);
    rd_ch = 2'd2;
    #1;
    total++; if (rd_cnt !== 2'd1) begin bad++; $display("FAIL cc_pre_cnt got=%0d exp=1", rd_cnt); end
    req = 4'b0100; bit_in = 4'b0100; clr = 1'b1; clr_ch = 2'd2;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL cc_gnt got=%b exp=0000", gnt); end
    step(g);
    clr = 1'b0;
    total++; if (det_valid !== 1'b0) begin bad++; $display("FAIL cc_det got=%b exp=0", det_valid); end
    #1;
    total++; if (rd_cnt !== 2'd0) begin bad++; $display("FAIL cc_cnt got=%0d exp=0", rd_cnt); end
    req = 4'b1111; bit_in = 4'b0000;
    #1;
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL cc_ptr_gnt got=%b exp=0100", gnt); end
    step(g);
    total++; if (det_valid !== 1'b0) begin bad++; $display("FAIL cc_det0 got=%b exp=0", det_valid); end
    req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      bit_in = {1'b0, b2[k], 2'b00};
      #1;
      step(g);
      exp = (k == 5);
      total++; if (det_valid !== exp) begin bad++; $display("FAIL cc_re_det k=%0d got=%b exp=%b", k, det_valid, exp); end
    end
    req = '0;
    #1;
    total++; if (rd_cnt !== 2'd1) begin bad++; $display("FAIL cc_post_cnt got=%0d exp=1", rd_cnt); end
  endtask

  task automatic test_saturation();
    logic [15:0] s16;
    logic exp;
    int nm, ec;
    s16 = 16'b1001001001001001;
    nm = 0;
    apply_reset();
    req = 4'b0001;
    rd_ch = 2'd0;
    for (int k = 0; k < 16; k++) begin
      bit_in = {3'b000, s16[15-k]};
      #1;
      step(g);
      exp = (k >= 3) && ((k - 3) % 3 == 0);
      if (exp) nm++;
      ec = (nm > CMAX) ? CMAX : nm;
      total++; if (det_valid !== exp) begin bad++; $display("FAIL sat_det k=%0d got=%b exp=%b", k, det_valid, exp); end
      total++; if (int'(rd_cnt) != ec) begin bad++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, rd_cnt, ec); end
    end
    req = '0;
    #1;
    total++; if (rd_cnt !== 2'd3) begin bad++; $display("FAIL sat_final got=%0d exp=3", rd_cnt); end
  endtask

  task automatic test_async_reset();
    int ch_t [7] = '{0, 1, 0, 1, 0, 1, 1};
    bit b_t  [7] = '{1, 1, 0, 0, 0, 0, 1};
    bit b3   [3] = '{0, 0, 1};
    logic exp;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      req = 4'b0001 << ch_t[i];
      bit_in = '0;
      bit_in[ch_t[i]] = b_t[i];
      #1;
      step(g);
    end
    total++; if (det_valid !== 1'b1 || det_ch !== 2'd1) begin bad++; $display("FAIL ar_pre_det got=%b/%0d exp=1/1", det_valid, det_ch); end
    req = 4'b0001; bit_in = 4'b0001;
    #2;
    rst = 1'b0;
    #1;
    total++; if (det_valid !== 1'b0) begin bad++; $display("FAIL ar_det_valid got=%b exp=0", det_valid); end
    total++; if (det_ch !== 2'd0) begin bad++; $display("FAIL ar_det_ch got=%0d exp=0", det_ch); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL ar_gnt got=%b exp=0000", gnt); end
    rd_ch = 2'd1;
    #1;
    total++; if (rd_cnt !== 2'd0) begin bad++; $display("FAIL ar_cnt got=%0d exp=0", rd_cnt); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL ar_rel_gnt got=%b exp=0001", gnt); end
    step(g);
    total++; if (det_valid !== 1'b0) begin bad++; $display("FAIL ar_single got=%b exp=0", det_valid); end
    for (int k = 0; k < 3; k++) begin
      bit_in = {3'b000, b3[k]};
      #1;
      step(g);
      exp = (k == 2);
      total++; if (det_valid !== exp) begin bad++; $display("FAIL ar_full k=%0d got=%b exp=%b", k, det_valid, exp); end
    end
    total++; if (det_ch !== 2'd0) begin bad++; $display("FAIL ar_full_ch got=%0d exp=0", det_ch); end
    req = '0;
  endtask

  task automatic test_random();
    logic [NCH-1:0] eg;
    apply_reset();
    for (int c = 0; c < NCH; c++) begin
      req[c] = ($urandom_range(0, 2) != 0);
      bit_in[c] = 1'($urandom_range(0, 1));
    end
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 11) == 0);
      clr_ch = 2'($urandom_range(0, NCH - 1));
      rd_ch = 2'($urandom_range(0, NCH - 1));
      #1;
      eg = model_gnt();
      total++; if (gnt !== eg) begin bad++; $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, gnt, eg); end
      total++; if (int'(rd_cnt) != m_cnt[rd_ch]) begin bad++; $display("FAIL rnd_cnt n=%0d ch=%0d got=%0d exp=%0d", n, rd_ch, rd_cnt, m_cnt[rd_ch]); end
      step(g);
      total++; if (det_valid !== m_det) begin bad++; $display("FAIL rnd_det n=%0d got=%b exp=%b", n, det_valid, m_det); end
      if (m_det) begin
        total++; if (int'(det_ch) != m_det_ch) begin bad++; $display("FAIL rnd_det_ch n=%0d got=%0d exp=%0d", n, det_ch, m_det_ch); end
      end
      for (int c = 0; c < NCH; c++) begin
        if (g[c] || !req[c]) begin
          req[c] = ($urandom_range(0, 2) != 0);
          bit_in[c] = 1'($urandom_range(0, 1));
        end
      end
    end
    req = '0; clr = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_no_crosstalk();
    test_clear_collision();
    test_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
